// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register interface slave.
package axi4_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_CAPT,
        R_RESP
    } rd_state_e;

    // Number of byte-offset address bits for a given bus width.
    function automatic int unsigned axi_lsb(input int unsigned data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int unsigned axi_idx_w(input int unsigned num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

endpackage

// File: rtl/axi4_lite_regif_if.sv
// AXI4-Lite bus bundle between the interconnect master and the register slave.
interface axi4_lite_regif_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] S_AXI_AWADDR;
    logic [2:0]        S_AXI_AWPROT;
    logic              S_AXI_AWVALID;
    logic              S_AXI_AWREADY;
    logic [DATA_W-1:0] S_AXI_WDATA;
    logic [STRB_W-1:0] S_AXI_WSTRB;
    logic              S_AXI_WVALID;
    logic              S_AXI_WREADY;
    logic [1:0]        S_AXI_BRESP;
    logic              S_AXI_BVALID;
    logic              S_AXI_BREADY;
    logic [ADDR_W-1:0] S_AXI_ARADDR;
    logic [2:0]        S_AXI_ARPROT;
    logic              S_AXI_ARVALID;
    logic              S_AXI_ARREADY;
    logic [DATA_W-1:0] S_AXI_RDATA;
    logic [1:0]        S_AXI_RRESP;
    logic              S_AXI_RVALID;
    logic              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/axi4_lite_addr_decode.sv
// Combinational byte-address to register-index decode with DECERR/SLVERR classification.
module axi4_lite_addr_decode
    import axi4_lite_pkg::*;
#(
    parameter  int unsigned ADDR_W   = 8,
    parameter  int unsigned DATA_W   = 32,
    parameter  int unsigned NUM_REGS = 5,
    localparam int unsigned IDX_W    = axi_idx_w(NUM_REGS)
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              busy,
    output logic [IDX_W-1:0]  idx,
    output axi_resp_e         resp
);

    localparam int unsigned LSB = axi_lsb(DATA_W);
    localparam int unsigned FW  = ADDR_W - LSB;
    localparam int unsigned FWP = FW + 1;

    logic [FW-1:0] full_idx;

    assign full_idx = addr[ADDR_W-1:LSB];
    assign idx      = IDX_W'(full_idx);

    // Out-of-range index wins over misalignment and busy.
    always_comb begin
        resp = RESP_OKAY;
        if ({1'b0, full_idx} >= FWP'(NUM_REGS)) begin
            resp = RESP_DECERR;
        end else if ((addr[LSB-1:0] != '0) || busy) begin
            resp = RESP_SLVERR;
        end
    end

endmodule

// File: rtl/axi4_lite_regif.sv
// AXI4-Lite slave bridging an interconnect master to a word-indexed register bank,
// with independent write (AW/W in any order) and read (registered fetch) channels.
module axi4_lite_regif
    import axi4_lite_pkg::*;
#(
    parameter  int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter  int unsigned C_S_AXI_ADDR_WIDTH = 8,
    parameter  int unsigned NUM_REGS           = 5,
    localparam int unsigned IDX_W              = axi_idx_w(NUM_REGS),
    localparam int unsigned STRB_W             = C_S_AXI_DATA_WIDTH / 8
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    axi4_lite_regif_if.slave              s_axi,
    input  logic                          i_is_busy,
    output logic                          o_wr_en,
    output logic [IDX_W-1:0]              o_wr_idx,
    output logic [C_S_AXI_DATA_WIDTH-1:0] o_wr_data,
    output logic [STRB_W-1:0]             o_wr_strb,
    output logic                          o_rd_en,
    output logic [IDX_W-1:0]              o_rd_idx,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] i_rd_data
);

    localparam int unsigned DATA_W = C_S_AXI_DATA_WIDTH;
    localparam int unsigned ADDR_W = C_S_AXI_ADDR_WIDTH;

    wr_state_e         wr_state_q, wr_state_d;
    rd_state_e         rd_state_q, rd_state_d;
    logic              aw_held_q, w_held_q;
    logic [ADDR_W-1:0] awaddr_q, araddr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [STRB_W-1:0] wstrb_q;
    axi_resp_e         bresp_q, rresp_q;

    logic              awready_c, wready_c, bvalid_c, arready_c, rvalid_c;
    logic              aw_hs_c, w_hs_c, ar_hs_c;
    logic [IDX_W-1:0]  wr_idx_c, rd_idx_c;
    axi_resp_e         wr_resp_c, rd_resp_c;
    logic              unused_prot_c;

    axi4_lite_addr_decode #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_wr_decode (
        .addr (awaddr_q),
        .busy (i_is_busy),
        .idx  (wr_idx_c),
        .resp (wr_resp_c)
    );

    axi4_lite_addr_decode #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rd_decode (
        .addr (araddr_q),
        .busy (i_is_busy),
        .idx  (rd_idx_c),
        .resp (rd_resp_c)
    );

    assign aw_hs_c = s_axi.S_AXI_AWVALID && awready_c;
    assign w_hs_c  = s_axi.S_AXI_WVALID  && wready_c;
    assign ar_hs_c = s_axi.S_AXI_ARVALID && arready_c;

    assign s_axi.S_AXI_AWREADY = awready_c;
    assign s_axi.S_AXI_WREADY  = wready_c;
    assign s_axi.S_AXI_BVALID  = bvalid_c;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_ARREADY = arready_c;
    assign s_axi.S_AXI_RVALID  = rvalid_c;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

    assign unused_prot_c = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT};

    // ---------------- write channel ----------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) wr_state_q <= W_IDLE;
        else              wr_state_q <= wr_state_d;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            W_IDLE:  if ((aw_held_q || aw_hs_c) && (w_held_q || w_hs_c)) wr_state_d = W_EXEC;
            W_EXEC:  wr_state_d = W_RESP;
            W_RESP:  if (s_axi.S_AXI_BREADY) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    // Bank-side write strobes exist only in W_EXEC; everything is quiet under reset.
    always_comb begin
        awready_c = 1'b0;
        wready_c  = 1'b0;
        bvalid_c  = 1'b0;
        o_wr_en   = 1'b0;
        o_wr_idx  = '0;
        o_wr_data = '0;
        o_wr_strb = '0;
        if (!S_AXI_ARESET) begin
            unique case (wr_state_q)
                W_IDLE: begin
                    awready_c = !aw_held_q;
                    wready_c  = !w_held_q;
                end
                W_EXEC: begin
                    o_wr_en   = (wr_resp_c == RESP_OKAY) && (wstrb_q != '0);
                    o_wr_idx  = wr_idx_c;
                    o_wr_data = wdata_q;
                    o_wr_strb = wstrb_q;
                end
                W_RESP:  bvalid_c = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
        end else begin
            if (aw_hs_c) begin
                aw_held_q <= 1'b1;
                awaddr_q  <= s_axi.S_AXI_AWADDR;
            end
            if (w_hs_c) begin
                w_held_q <= 1'b1;
                wdata_q  <= s_axi.S_AXI_WDATA;
                wstrb_q  <= s_axi.S_AXI_WSTRB;
            end
            if (wr_state_q == W_EXEC) bresp_q <= wr_resp_c;
            if (bvalid_c && s_axi.S_AXI_BREADY) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) rd_state_q <= R_IDLE;
        else              rd_state_q <= rd_state_d;
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            R_IDLE:  if (ar_hs_c) rd_state_d = R_FETCH;
            R_FETCH: rd_state_d = R_CAPT;
            R_CAPT:  rd_state_d = R_RESP;
            R_RESP:  if (s_axi.S_AXI_RREADY) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        arready_c = 1'b0;
        rvalid_c  = 1'b0;
        o_rd_en   = 1'b0;
        o_rd_idx  = '0;
        if (!S_AXI_ARESET) begin
            unique case (rd_state_q)
                R_IDLE:  arready_c = 1'b1;
                R_FETCH: begin
                    o_rd_en  = (rd_resp_c == RESP_OKAY);
                    o_rd_idx = (rd_resp_c == RESP_OKAY) ? rd_idx_c : '0;
                end
                R_RESP:  rvalid_c = 1'b1;
                default: ;
            endcase
        end
    end

    // Bank data arrives the cycle after the fetch pulse; errored reads return zero.
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            araddr_q <= '0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= '0;
        end else begin
            if (ar_hs_c) araddr_q <= s_axi.S_AXI_ARADDR;
            if (rd_state_q == R_FETCH) rresp_q <= rd_resp_c;
            if (rd_state_q == R_CAPT) rdata_q <= (rresp_q == RESP_OKAY) ? i_rd_data : '0;
        end
    end

endmodule

// File: doc/axi4_lite_regif.md
# axi4_lite_regif

Parametrised AXI4-Lite slave that bridges a PS/interconnect master to a word-indexed register bank of `NUM_REGS` entries. It generalises the single-width, fixed-range adder slave:
- configurable data width and register count;
- AW and W accepted in either order;
- alignment checking, and DECERR distinct from SLVERR;
- fully held B/R responses;
- a registered read-fetch cycle towards the bank.

It sits between the AXI interconnect and the register bank and control logic of an accelerator IP.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32, bus/register width; legal values are 32 and 64.
- `C_S_AXI_ADDR_WIDTH`, 8, byte-address width.
- `NUM_REGS`, 5, number of registers; legal range is 1 to 2^(ADDR_W−LSB). LSB = log2(DATA_W/8); IDX_W = max(1, clog2(NUM_REGS)).
- `S_AXI_ACLK` in 1: the only clock.
- `S_AXI_ARESET` in 1: reset, synchronous and active-high.
- AW channel:
  - `S_AXI_AWADDR` in ADDR_W
  - `S_AXI_AWPROT` in 3 (ignored)
  - `S_AXI_AWVALID` in 1
  - `S_AXI_AWREADY` out 1
- W channel:
  - `S_AXI_WDATA` in DATA_W
  - `S_AXI_WSTRB` in DATA_W/8
  - `S_AXI_WVALID` in 1
  - `S_AXI_WREADY` out 1
- B channel:
  - `S_AXI_BRESP` out 2
  - `S_AXI_BVALID` out 1
  - `S_AXI_BREADY` in 1
- AR channel:
  - `S_AXI_ARADDR` in ADDR_W
  - `S_AXI_ARPROT` in 3 (ignored)
  - `S_AXI_ARVALID` in 1
  - `S_AXI_ARREADY` out 1
- R channel:
  - `S_AXI_RDATA` out DATA_W
  - `S_AXI_RRESP` out 2
  - `S_AXI_RVALID` out 1
  - `S_AXI_RREADY` in 1
- `i_is_busy` in 1: IP busy; causes SLVERR on any access evaluated while high.
- Write port to the bank:
  - `o_wr_en` out 1: single-cycle write pulse.
  - `o_wr_idx` out IDX_W.
  - `o_wr_data` out DATA_W.
  - `o_wr_strb` out DATA_W/8.
- Read port to the bank:
  - `o_rd_en` out 1: single-cycle read pulse.
  - `o_rd_idx` out IDX_W.
  - `i_rd_data` in DATA_W: valid in the cycle after `o_rd_en`.

## Operation
- **Reset values:** every output is 0, BRESP/RRESP are OKAY, and both FSMs are in IDLE. Reset mid-transaction drops any pending AW, W or AR and drops held responses; no bank pulse is issued.
- **Decode (identical for both channels):**
  - idx = addr[ADDR_W−1:LSB].
  - DECERR (2'b11) if idx ≥ NUM_REGS.
  - Otherwise SLVERR (2'b10) if addr[LSB−1:0] ≠ 0 or `i_is_busy` = 1 in the evaluation cycle.
  - Otherwise OKAY.
- **Write FSM states:** W_IDLE → W_EXEC → W_RESP → W_IDLE.
  - W_IDLE:
    - AWREADY = !aw_held and WREADY = !w_held; each channel is latched independently on its handshake.
    - Both handshakes in the same cycle are allowed.
    - The FSM moves to W_EXEC in the cycle after both aw_held and w_held are set.
  - W_EXEC (1 cycle):
    - Evaluate decode and register BRESP.
    - Pulse `o_wr_en` only if OKAY and WSTRB ≠ 0. WSTRB = 0 with a legal address gives OKAY with no pulse.
    - `o_wr_idx`, `o_wr_data` and `o_wr_strb` carry the latched values in this cycle and are 0 otherwise.
  - W_RESP:
    - BVALID = 1; BRESP is held stable until BREADY.
    - On the BVALID&&BREADY cycle, clear both held flags and return to W_IDLE. AWREADY and WREADY are 0 in this state.
- **Read FSM states:** R_IDLE → R_FETCH → R_CAPT → R_RESP → R_IDLE.
  - R_IDLE: ARREADY = 1; latch ARADDR on handshake.
  - R_FETCH: evaluate decode; pulse `o_rd_en` with `o_rd_idx` only if OKAY; register RRESP.
  - R_CAPT: register RDATA = `i_rd_data` if OKAY, else 0.
  - R_RESP: RVALID = 1, RDATA and RRESP stable until RREADY, then R_IDLE.
- **Channel independence:** the channels are fully independent. No ordering is enforced between reads and writes; bank-side read/write collision semantics belong to the bank. At most one outstanding write and one outstanding read.

## Timing
- **Write (AW and W both accepted in cycle T):** `o_wr_en` at T+1, BVALID from T+2, earliest next AWREADY at T+3 if BREADY is high at T+2.
- **Write, AW at T and W at T+k:** the W_EXEC cycle (carrying `o_wr_en`) is T+k+1.
- **Read (AR accepted at T):** `o_rd_en` at T+1, `i_rd_data` sampled at T+2, RVALID from T+3, next ARREADY at T+4 at the earliest.
- **Busy sampling:** `i_is_busy` is sampled in the W_EXEC/R_FETCH cycle only. Changes after that do not alter a held response.
- **Backpressure:** BREADY/RREADY held low keeps VALID, RESP and DATA constant indefinitely.

## Structure
- Package `axi4_lite_pkg` holds:
  - the resp enum (OKAY, EXOKAY, SLVERR, DECERR);
  - write/read FSM state typedefs;
  - function `axi_lsb(data_w)`.
- Sub-module `axi4_lite_addr_decode` is combinational and parametrised by ADDR_W, DATA_W and NUM_REGS. Inputs: addr and busy. Outputs: idx and resp. It is instantiated once per channel.
- The FSMs and held registers stay in `axi4_lite_regif`.

## Test plan
1. AW=0x08 at T, W=0xDEADBEEF with STRB=0xF at T+3, BREADY=1 → `o_wr_en` at T+4 with idx=2 and data 0xDEADBEEF, BVALID at T+5 with BRESP=OKAY.
2. W before AW (W at T, AW at T+2), STRB=0x3 → single `o_wr_en` with strb=0x3; AWREADY=0 and WREADY=0 for the whole of W_EXEC and W_RESP.
3. Write to AWADDR 0x14 (NUM_REGS=5) → BRESP=DECERR, no `o_wr_en`. Write to 0x06 → SLVERR. Read from 0x14 → RRESP=DECERR with RDATA=0.
4. Read from 0x04 with `i_rd_data`=0x12345678 at T+2 and RREADY held low for 5 cycles → RVALID, RDATA and RRESP stable, then a one-cycle handshake and a return to ARREADY=1.
5. `i_is_busy`=1 during W_EXEC and R_FETCH → SLVERR on both with no bank pulses. Busy dropping during W_RESP → BRESP stays SLVERR.
6. `S_AXI_ARESET` asserted in W_RESP and R_CAPT → next cycle all outputs are 0 and the FSMs are IDLE. A new write afterwards completes normally. Repeat with DATA_W=64 and NUM_REGS=16: AW=0x78 → idx=15, AW=0x80 → DECERR.
